// File: rtl/instr_fetch_fsm.sv
// Instruction-fetch controller: walks PC->MAR->memory->MDR->IR and holds the
// execution FSMs idle (IF_active) until IR is stable, then waits for exec_done.
module instr_fetch_fsm #(
    parameter int unsigned EXEC_TIMEOUT = 32,
    parameter logic [15:0] NOP_WORD     = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] bus_in,
    input  logic        mem_ack,
    input  logic        exec_done,
    output logic [15:0] fullBitNum,
    output logic        IF_active,
    output logic        PC_out,
    output logic        MAR_in,
    output logic        mem_rd,
    output logic        MDR_out,
    output logic        PC_inc,
    output logic        halted,
    output logic [15:0] instr_count
);

    // One spare bit so the counter can never wrap before reaching EXEC_TIMEOUT-1.
    localparam int unsigned CntW = $clog2(EXEC_TIMEOUT) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(EXEC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StRead,
        StLoad,
        StDecode,
        StNopInc,
        StExec,
        StHalt
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [CntW-1:0]   tmo_q, tmo_d;
    logic [15:0]       count_q, count_d;
    logic              halted_q, halted_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            ir_q     <= 16'h0000;
            tmo_q    <= '0;
            count_q  <= 16'h0000;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            tmo_q    <= tmo_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        tmo_d     = tmo_q;
        count_d   = count_q;
        halted_d  = halted_q;
        IF_active = 1'b1;
        PC_out    = 1'b0;
        MAR_in    = 1'b0;
        mem_rd    = 1'b0;
        MDR_out   = 1'b0;
        PC_inc    = 1'b0;

        case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StAddr;
                end
            end
            StAddr: begin
                PC_out  = 1'b1;
                MAR_in  = 1'b1;
                state_d = StRead;
            end
            StRead: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                MDR_out = 1'b1;
                ir_d    = bus_in;
                state_d = StDecode;
            end
            StDecode: begin
                if (ir_q == NOP_WORD) begin
                    state_d = StNopInc;
                end else begin
                    tmo_d   = '0;
                    state_d = StExec;
                end
            end
            StNopInc: begin
                PC_inc  = 1'b1;
                count_d = count_q + 16'd1;
                state_d = run ? StAddr : StIdle;
            end
            StExec: begin
                IF_active = 1'b0;
                tmo_d     = tmo_q + CntW'(1);
                // Done takes priority over a timeout landing on the same cycle.
                if (exec_done) begin
                    count_d = count_q + 16'd1;
                    state_d = run ? StAddr : StIdle;
                end else if (tmo_q == CntLast) begin
                    halted_d = 1'b1;
                    state_d  = StHalt;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign fullBitNum  = ir_q;
    assign instr_count = count_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_fsm.sv
// Directed bench for instr_fetch_fsm: a vector table for the main fetch/NOP flow
// plus hand-written sequences for timeout, async reset and counter wrap.
module tb_instr_fetch_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [15:0] bus_in;
    logic        mem_ack;
    logic        exec_done;
    logic [15:0] fullBitNum;
    logic        IF_active;
    logic        PC_out;
    logic        MAR_in;
    logic        mem_rd;
    logic        MDR_out;
    logic        PC_inc;
    logic        halted;
    logic [15:0] instr_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_fetch_fsm #(
        .EXEC_TIMEOUT(32),
        .NOP_WORD    (16'h0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .bus_in     (bus_in),
        .mem_ack    (mem_ack),
        .exec_done  (exec_done),
        .fullBitNum (fullBitNum),
        .IF_active  (IF_active),
        .PC_out     (PC_out),
        .MAR_in     (MAR_in),
        .mem_rd     (mem_rd),
        .MDR_out    (MDR_out),
        .PC_inc     (PC_inc),
        .halted     (halted),
        .instr_count(instr_count)
    );

    // {IF_active, PC_out, MAR_in, mem_rd, MDR_out, PC_inc, halted}
    localparam logic [6:0] S_IDLE = 7'b1000000;
    localparam logic [6:0] S_ADDR = 7'b1110000;
    localparam logic [6:0] S_READ = 7'b1001000;
    localparam logic [6:0] S_LOAD = 7'b1000100;
    localparam logic [6:0] S_DEC  = 7'b1000000;
    localparam logic [6:0] S_NOP  = 7'b1000010;
    localparam logic [6:0] S_EXEC = 7'b0000000;
    localparam logic [6:0] S_HALT = 7'b1000001;

    typedef struct {
        logic        run;
        logic        ack;
        logic        done;
        logic [15:0] bus;
        logic [6:0]  exp_sig;
        logic [15:0] exp_ir;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [6:0] sig();
        return {IF_active, PC_out, MAR_in, mem_rd, MDR_out, PC_inc, halted};
    endfunction

    function automatic void add(logic r, logic a, logic d, logic [15:0] b,
                                logic [6:0] s, logic [15:0] ir, logic [15:0] c);
        vec_t v;
        v.run = r; v.ack = a; v.done = d; v.bus = b;
        v.exp_sig = s; v.exp_ir = ir; v.exp_cnt = c;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [6:0] s, input logic [15:0] ir,
                           input logic [15:0] c);
        chk({name, ".sig"}, {25'd0, sig()}, {25'd0, s});
        chk({name, ".ir"}, {16'd0, fullBitNum}, {16'd0, ir});
        chk({name, ".cnt"}, {16'd0, instr_count}, {16'd0, c});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives the ADDR..DECODE fetch and leaves the DUT in the first EXEC cycle.
    task automatic fetch_to_exec(input logic [15:0] word);
        run = 1'b1; mem_ack = 1'b1; exec_done = 1'b0; bus_in = word;
        repeat (5) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic saw_rd;
        logic all_halt;

        // Main flow table: 10 idle cycles, 9042 fetch/exec, NOP with slow ack,
        // then run dropped during READ.
        for (int i = 0; i < 10; i++) add(1'b0, 1'b0, (i == 5), 16'h1111, S_IDLE, 16'h0, 16'd0);
        add(1, 1, 0, 16'h9042, S_ADDR, 16'h0000, 16'd0);
        add(1, 1, 0, 16'h9042, S_READ, 16'h0000, 16'd0);
        add(1, 1, 0, 16'h9042, S_LOAD, 16'h0000, 16'd0);
        add(1, 1, 0, 16'h9042, S_DEC,  16'h9042, 16'd0);
        add(1, 1, 0, 16'h9042, S_EXEC, 16'h9042, 16'd0);
        for (int i = 0; i < 9; i++) add(1, 1, 0, 16'hFFFF, S_EXEC, 16'h9042, 16'd0);
        add(1, 1, 1, 16'hFFFF, S_ADDR, 16'h9042, 16'd1);
        add(1, 0, 0, 16'hFFFF, S_READ, 16'h9042, 16'd1);
        for (int i = 0; i < 5; i++) add(1, 0, (i == 2), 16'hFFFF, S_READ, 16'h9042, 16'd1);
        add(1, 1, 0, 16'h0000, S_LOAD, 16'h9042, 16'd1);
        add(1, 1, 0, 16'h0000, S_DEC,  16'h0000, 16'd1);
        add(1, 1, 0, 16'h0000, S_NOP,  16'h0000, 16'd1);
        add(1, 0, 0, 16'h0000, S_ADDR, 16'h0000, 16'd2);
        add(0, 0, 0, 16'h0000, S_READ, 16'h0000, 16'd2);
        add(0, 1, 0, 16'h1234, S_LOAD, 16'h0000, 16'd2);
        add(0, 1, 0, 16'h1234, S_DEC,  16'h1234, 16'd2);
        add(0, 1, 0, 16'h1234, S_EXEC, 16'h1234, 16'd2);
        add(0, 1, 1, 16'h1234, S_IDLE, 16'h1234, 16'd3);
        add(0, 0, 0, 16'h1234, S_IDLE, 16'h1234, 16'd3);

        rst = 1'b1; run = 1'b0; mem_ack = 1'b0; exec_done = 1'b0; bus_in = 16'h0;
        #12;
        chk_all("reset", S_IDLE, 16'h0000, 16'd0);
        rst = 1'b0;
        #5;

        foreach (tbl[i]) begin
            run = tbl[i].run; mem_ack = tbl[i].ack;
            exec_done = tbl[i].done; bus_in = tbl[i].bus;
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].exp_sig, tbl[i].exp_ir, tbl[i].exp_cnt);
        end

        // exec_done arriving exactly on the timeout cycle wins.
        fetch_to_exec(16'hABCD);
        chk_all("tmo_edge.exec1", S_EXEC, 16'hABCD, 16'd3);
        repeat (31) step();
        chk("tmo_edge.exec32", {31'd0, IF_active}, 32'd0);
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        chk_all("tmo_edge.done", S_ADDR, 16'hABCD, 16'd4);

        // Async reset in the middle of EXEC.
        fetch_to_exec(16'h5555);
        repeat (3) step();
        chk_all("midexec.before", S_EXEC, 16'h5555, 16'd4);
        #2 rst = 1'b1;
        #1;
        chk_all("midexec.async_rst", S_IDLE, 16'h0000, 16'd0);
        #2 rst = 1'b0;

        // Timeout: count EXEC cycles until the DUT leaves, expect HALT after 32.
        fetch_to_exec(16'h7777);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            if (IF_active == 1'b0) begin
                step();
                if (IF_active == 1'b0) n++;
            end
        end
        chk("tmo.exec_cycles", n, 32);
        chk_all("tmo.halt", S_HALT, 16'h7777, 16'd0);
        saw_rd = 1'b0; all_halt = 1'b1;
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (mem_rd) saw_rd = 1'b1;
            if (sig() != S_HALT) all_halt = 1'b0;
        end
        chk("tmo.no_rd", {31'd0, saw_rd}, 32'd0);
        chk("tmo.sticky", {31'd0, all_halt}, 32'd1);
        run = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_all("tmo.rst_clears", S_IDLE, 16'h0000, 16'd0);
        #2 rst = 1'b0;

        // Counter wrap: preload near the top, then two NOP completions.
        force dut.count_q = 16'hFFFE;
        step();
        release dut.count_q;
        chk("wrap.preset", {16'd0, instr_count}, 32'h0000FFFE);
        run = 1'b1; mem_ack = 1'b1; bus_in = 16'h0000;
        repeat (5) step();
        chk_all("wrap.nop1", S_NOP, 16'h0000, 16'hFFFE);
        step();
        chk_all("wrap.ffff", S_ADDR, 16'h0000, 16'hFFFF);
        repeat (4) step();
        chk_all("wrap.nop2", S_NOP, 16'h0000, 16'hFFFF);
        run = 1'b0;
        step();
        chk_all("wrap.zero", S_IDLE, 16'h0000, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
